// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a synchronous FIFO one word per frame.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
module uart_tx_drain #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_empty,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);
    localparam logic ParEn  = (PARITY_EN != 0);
    localparam logic ParOdd = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [IdxW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;

    logic                  w_bit_end;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    assign w_bit_end   = (r_cnt == CntLast);
    assign w_rd        = rst_n && (r_state == StIdle) && !i_empty;
    assign w_shift_nxt = r_shift >> 1;

    assign o_rd_en = w_rd;
    assign o_busy  = rst_n && (r_state != StIdle);
    assign o_tx    = r_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    r_tx  <= 1'b1;
                    if (w_rd) begin
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_shift <= i_rd_data;
                    r_idx   <= '0;
                    r_par   <= ParOdd;
                    r_cnt   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= StStart;
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= StData;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= w_shift_nxt;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IdxLast) begin
                            // Line level is set on the edge that enters the next state.
                            if (ParEn) begin
                                r_tx    <= r_par ^ r_shift[0];
                                r_state <= StParity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end
                        end else begin
                            r_tx <= w_shift_nxt[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StParity: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= StStop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
